// File: rtl/demux_seq_pkg.sv
// ----------------------------------------------------------------------------
// demux_seq_pkg : shared encodings and helpers for the demux select sequencer
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demux_seq_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DRIVE  = 2'd2;

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return (ch == SEL_W'(N_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_hold_cnt.sv
// ----------------------------------------------------------------------------
// demux_hold_cnt : loadable down-counter timing the DRIVE phase
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux_hold_cnt #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [HOLD_W-1:0] load_val_i,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/demux_sel_sequencer.sv
// ----------------------------------------------------------------------------
// demux_sel_sequencer : request/scan sequencer driving a 1x8 demux Din and S
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int HOLD_W    = 4,
  parameter int SCAN_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_ch,
  input  logic              req_data,
  input  logic [HOLD_W-1:0] req_hold,
  input  logic              scan_en,
  output logic              Din,
  output logic [SEL_W-1:0]  S,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  ch_q, scan_ptr_q;
  logic              data_q, is_req_q;
  logic [HOLD_W-1:0] hold_q;
  logic [SEL_W-1:0]  s_q, s_d;
  logic              din_q, din_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic              w_idle, w_start, w_cnt_zero, w_drive_end, w_cnt_load;
  logic [SEL_W-1:0]  w_new_ch;
  logic              w_new_data;
  logic [HOLD_W-1:0] w_new_hold, w_load_val;

  // A pending request always wins over starting a scan transaction.
  assign w_idle      = (state_q == ST_IDLE);
  assign w_start     = w_idle && (req_valid || scan_en);
  assign w_new_ch    = req_valid ? req_ch   : scan_ptr_q;
  assign w_new_data  = req_valid ? req_data : 1'b1;
  assign w_new_hold  = req_valid ? req_hold : HOLD_W'(SCAN_HOLD);
  assign w_drive_end = (state_q == ST_DRIVE) && w_cnt_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_start) state_d = (w_new_ch != s_q) ? ST_SETTLE : ST_DRIVE;
      ST_SETTLE: state_d = ST_DRIVE;
      ST_DRIVE:  if (w_cnt_zero) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic, computed for the state being entered and then registered
  always_comb begin
    s_d     = w_start ? w_new_ch : s_q;
    din_d   = 1'b0;
    if (state_d == ST_DRIVE) din_d = w_idle ? w_new_data : data_q;
    busy_d  = (state_d != ST_IDLE);
    done_d  = w_drive_end && is_req_q;
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      s_q     <= s_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      data_q     <= 1'b0;
      hold_q     <= '0;
      is_req_q   <= 1'b0;
      scan_ptr_q <= '0;
    end else begin
      if (w_start) begin
        ch_q     <= w_new_ch;
        data_q   <= w_new_data;
        hold_q   <= w_new_hold;
        is_req_q <= req_valid;
      end
      if (w_drive_end && !is_req_q) scan_ptr_q <= next_ch(ch_q);
    end
  end

  // Counter is loaded on the edge that enters DRIVE, from either IDLE or SETTLE.
  assign w_cnt_load = (w_idle && w_start && (state_d == ST_DRIVE)) || (state_q == ST_SETTLE);
  assign w_load_val = w_idle ? w_new_hold : hold_q;

  demux_hold_cnt #(
    .HOLD_W (HOLD_W)
  ) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_cnt_load),
    .en_i       (state_q == ST_DRIVE),
    .load_val_i (w_load_val),
    .zero_o     (w_cnt_zero)
  );

  assign S         = s_q;
  assign Din       = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

endmodule

`default_nettype wire
